span_fill_engine: RTL and testbench

SPAN_FILL_ENGINE -- requirements
Module: span_fill_engine

---
 rtl/gpu_fill_pkg.sv | 22 ++
 rtl/span_edge_finder.sv | 26 ++
 rtl/span_fill_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_span_fill_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_fill_pkg.sv
// Shared definitions for the span fill engine: FSM state codes, fill-mode
// encoding and the default address strides of the layer/row memory layout.
package gpu_fill_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Fill modes: span colours first..last set bit, mask colours set bits only
    localparam logic MODE_SPAN = 1'b0;
    localparam logic MODE_MASK = 1'b1;

    // Default memory layout, in address units
    localparam int DEF_LAYER_BASE_STRIDE = 65536;
    localparam int DEF_ROW_STRIDE        = 256;

endpackage

// File: rtl/span_edge_finder.sv
// Combinational finder for the lowest and highest set bit of one row mask.
// valid_o is low for an all-zero row; the indices are then zero.
module span_edge_finder #(
    parameter int SPAN_PIX = 64,
    localparam int IDX_W   = (SPAN_PIX > 1) ? $clog2(SPAN_PIX) : 1
) (
    input  logic [SPAN_PIX-1:0] mask_i,
    output logic [IDX_W-1:0]    first_o,
    output logic [IDX_W-1:0]    last_o,
    output logic                valid_o
);

    // Priority scans in both directions; the last hit in each loop wins
    always_comb begin
        first_o = '0;
        last_o  = '0;
        valid_o = |mask_i;
        for (int i = SPAN_PIX - 1; i >= 0; i--) begin
            if (mask_i[i]) first_o = IDX_W'(i);
        end
        for (int i = 0; i < SPAN_PIX; i++) begin
            if (mask_i[i]) last_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/span_fill_engine.sv
// Span fill engine: walks NUM_ROWS rows of a coverage mask and, for each
// non-empty row, read-modify-writes one SPAN_PIX-pixel memory word with the
// fill colour. All outputs come straight from registers.
module span_fill_engine
    import gpu_fill_pkg::*;
#(
    parameter int ADDR_W            = 24,
    parameter int PIX_W             = 24,
    parameter int SPAN_PIX          = 64,
    parameter int NUM_ROWS          = 64,
    parameter int NUM_LAYERS        = 2,
    parameter int LAYER_BASE_STRIDE = DEF_LAYER_BASE_STRIDE,
    parameter int ROW_STRIDE        = DEF_ROW_STRIDE,
    localparam int LW               = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         mode,
    input  logic [7:0]                   x0,
    input  logic [7:0]                   y0,
    input  logic [LW-1:0]                layer_sel,
    input  logic [PIX_W-1:0]             color,
    input  logic [SPAN_PIX*NUM_ROWS-1:0] row_mask,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [SPAN_PIX*PIX_W-1:0]    mem_wdata,
    input  logic [SPAN_PIX*PIX_W-1:0]    mem_rdata,
    input  logic                         mem_ack
);

    localparam int WORD_W = SPAN_PIX * PIX_W;
    localparam int RW     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int IW     = (SPAN_PIX > 1) ? $clog2(SPAN_PIX) : 1;
    localparam int MW     = (SPAN_PIX * NUM_ROWS > 1) ? $clog2(SPAN_PIX * NUM_ROWS) : 1;

    // Row address; the y coordinate wraps inside 8 bits before scaling
    function automatic logic [ADDR_W-1:0] row_addr(input logic [LW-1:0] layer,
                                                   input logic [7:0]    y,
                                                   input logic [7:0]    x);
        return ADDR_W'(64'(layer) * 64'(LAYER_BASE_STRIDE) +
                       64'(y) * 64'(ROW_STRIDE) + 64'(x));
    endfunction

    // Replace the covered pixels of a read word with the fill colour
    function automatic logic [WORD_W-1:0] merge_row(input logic [WORD_W-1:0]   rd,
                                                    input logic [SPAN_PIX-1:0] m,
                                                    input logic                md,
                                                    input logic [IW-1:0]       f,
                                                    input logic [IW-1:0]       l,
                                                    input logic [PIX_W-1:0]    c);
        logic [WORD_W-1:0] w;
        logic              hit;
        w = rd;
        for (int p = 0; p < SPAN_PIX; p++) begin
            case (md)
                MODE_SPAN: hit = (p >= int'(f)) && (p <= int'(l));
                MODE_MASK: hit = m[p];
                default:   hit = 1'b0;
            endcase
            if (hit) w[p*PIX_W +: PIX_W] = c;
        end
        return w;
    endfunction

    // Control and output registers
    logic [2:0]        state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;

    // Job fields, frozen for the duration of a job
    logic                         mode_q;
    logic [7:0]                   x0_q, y0_q;
    logic [LW-1:0]                layer_q;
    logic [PIX_W-1:0]             color_q;
    logic [SPAN_PIX*NUM_ROWS-1:0] mask_q;
    logic [IW-1:0]                first_q, last_q;
    logic                         latch_job;

    logic [MW-1:0]       row_base;
    logic [SPAN_PIX-1:0] cur_row;
    logic [IW-1:0]       edge_first, edge_last;
    logic                edge_vld;
    logic [7:0]          row_y;

    assign row_base = MW'(int'(row_q) * SPAN_PIX);
    assign cur_row  = mask_q[row_base +: SPAN_PIX];
    assign row_y    = y0_q + 8'(row_q);

    span_edge_finder #(
        .SPAN_PIX (SPAN_PIX)
    ) u_edge (
        .mask_i  (cur_row),
        .first_o (edge_first),
        .last_o  (edge_last),
        .valid_o (edge_vld)
    );

    // Next-state logic; abort outranks everything outside IDLE
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        data_d    = data_q;
        latch_job = 1'b0;
        if (state_q != ST_IDLE && abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            req_d   = 1'b0;
            we_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        latch_job = 1'b0 == 1'b0;
                        row_d     = '0;
                        busy_d    = 1'b1;
                        if (32'(layer_sel) >= NUM_LAYERS) begin
                            // Bad layer: no memory traffic, report at once
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            err_d   = 1'b0;
                            state_d = ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (edge_vld) begin
                        addr_d  = row_addr(layer_q, row_y, x0_q);
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        data_d  = mem_rdata;
                        req_d   = 1'b0;
                        state_d = ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    data_d  = merge_row(data_q, cur_row, mode_q, first_q, last_q, color_q);
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (row_q == RW'(NUM_ROWS - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end
                ST_DONE: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control/output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Job fields latch on an accepted start; span edges latch during SCAN
    always_ff @(posedge clk) begin
        if (latch_job) begin
            mode_q  <= mode;
            x0_q    <= x0;
            y0_q    <= y0;
            layer_q <= layer_sel;
            color_q <= color;
            mask_q  <= row_mask;
        end
        if (state_q == ST_SCAN) begin
            first_q <= edge_first;
            last_q  <= edge_last;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

endmodule

// File: tb/tb_span_fill_engine.sv
// Directed bench for span_fill_engine: table of fill jobs against a
// behavioural memory responder, plus abort and reset-mid-read sequences.
module tb_span_fill_engine;

    localparam int SP = 16;
    localparam int NR = 4;
    localparam int WW = SP * 24;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start, abort, mode;
    logic [7:0]    x0, y0;
    logic [1:0]    layer_sel;
    logic [23:0]   color;
    logic [SP*NR-1:0] row_mask;
    logic          busy, done, err, mem_req, mem_we, mem_ack;
    logic [23:0]   mem_addr;
    logic [WW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    span_fill_engine #(
        .ADDR_W(24), .PIX_W(24), .SPAN_PIX(SP), .NUM_ROWS(NR), .NUM_LAYERS(3)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .mode(mode),
        .x0(x0), .y0(y0), .layer_sel(layer_sel), .color(color), .row_mask(row_mask),
        .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int checks = 0;
    int errors = 0;

    // Responder state and transaction log
    int            ack_delay = 0;
    int            wcnt, req_cycles, rd_cnt, wr_cnt, done_cnt, stab_err, gap_err;
    bit            in_txn;
    logic [23:0]   t_addr;
    logic          t_we;
    logic [WW-1:0] t_wdata;
    logic [23:0]   rd_addr [8];
    logic [23:0]   wr_addr [8];
    logic [WW-1:0] wr_data [8];

    function automatic logic [WW-1:0] rd_word(input logic [23:0] a);
        logic [WW-1:0] w;
        for (int p = 0; p < SP; p++) w[p*24 +: 24] = a ^ {8'(p + 1), 16'h5A3C};
        return w;
    endfunction

    function automatic logic [WW-1:0] exp_word(input logic [23:0] a, input logic [15:0] cov,
                                               input logic [23:0] c);
        logic [WW-1:0] w;
        w = rd_word(a);
        for (int p = 0; p < SP; p++) if (cov[p]) w[p*24 +: 24] = c;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: acks after ack_delay cycles, logs and checks stability
    initial begin
        mem_ack = 1'b0; mem_rdata = '0; in_txn = 0; wcnt = 0;
        req_cycles = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; stab_err = 0; gap_err = 0;
        forever begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (!n_rst) begin
                mem_ack = 1'b0; in_txn = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0; in_txn = 0;
                if (mem_req) gap_err++;
            end else if (mem_req) begin
                req_cycles++;
                if (!in_txn) begin
                    in_txn = 1; wcnt = 0; t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata;
                end else if (mem_addr !== t_addr || mem_we !== t_we || mem_wdata !== t_wdata) begin
                    stab_err++;
                end
                if (wcnt == ack_delay) begin
                    mem_ack = 1'b1;
                    if (t_we) begin
                        wr_addr[wr_cnt % 8] = mem_addr; wr_data[wr_cnt % 8] = mem_wdata; wr_cnt++;
                    end else begin
                        rd_addr[rd_cnt % 8] = mem_addr; mem_rdata = rd_word(mem_addr); rd_cnt++;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                in_txn = 0;
            end
        end
    end

    typedef struct {
        string       name;
        logic        mode;
        logic [7:0]  x0, y0;
        logic [1:0]  layer;
        logic [23:0] color;
        logic [63:0] mask;
        int          delay;
        int          acc;
        logic [23:0] addr;
        logic [15:0] cov;
        logic        err;
        int          cycles;
        bit          poke;
        bit          start_in_done;
    } vec_t;

    vec_t vecs[8];

    task automatic run_job(input vec_t v);
        int cyc;
        rd_cnt = 0; wr_cnt = 0; req_cycles = 0;
        ack_delay = v.delay;
        mode = v.mode; x0 = v.x0; y0 = v.y0; layer_sel = v.layer;
        color = v.color; row_mask = v.mask; start = 1'b1;
        tick();
        start = 1'b0;
        chk({v.name, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 200) begin
            if (v.poke && cyc == 2) begin
                start = 1'b1; color = ~v.color; x0 = v.x0 + 8'd1; mode = ~v.mode;
                row_mask = ~v.mask;
            end
            if (v.poke && cyc == 3) start = 1'b0;
            tick();
            cyc++;
        end
        chk({v.name, "_done"}, done, 1);
        chk({v.name, "_cycles"}, cyc, v.cycles);
        chk({v.name, "_err"}, err, v.err);
        chk({v.name, "_reads"}, rd_cnt, v.acc);
        chk({v.name, "_writes"}, wr_cnt, v.acc);
        chk({v.name, "_req_cycles"}, req_cycles, 2 * v.acc * (v.delay + 1));
        if (v.acc > 0) begin
            chk({v.name, "_rd_addr"}, rd_addr[0], v.addr);
            chk({v.name, "_wr_addr"}, wr_addr[0], v.addr);
            chk({v.name, "_wdata"}, wr_data[0], exp_word(v.addr, v.cov, v.color));
        end
        if (v.start_in_done) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk({v.name, "_idle_after_done"}, busy, 0);
            tick();
            chk({v.name, "_start_in_done_ignored"}, busy, 0);
        end else begin
            tick();
            chk({v.name, "_idle_after_done"}, {busy, done}, 0);
        end
        chk({v.name, "_err_sticky"}, err, v.err);
    endtask

    initial begin
        int n0, wait_cyc;
        vec_t v;
        vecs[0] = '{"single_px", 1'b0, 8'd10, 8'd20, 2'd0, 24'hFF0000, 64'h0020,
                    0, 1, 24'h00140A, 16'h0020, 1'b0, 11, 1'b0, 1'b0};
        vecs[1] = '{"span_8001", 1'b0, 8'd0, 8'd0, 2'd0, 24'h0000FF, 64'h8001,
                    0, 1, 24'h000000, 16'hFFFF, 1'b0, 11, 1'b0, 1'b0};
        vecs[2] = '{"mask_8001", 1'b1, 8'd1, 8'd0, 2'd0, 24'h0000FF, 64'h8001,
                    0, 1, 24'h000001, 16'h8001, 1'b0, 11, 1'b0, 1'b0};
        vecs[3] = '{"empty", 1'b0, 8'd5, 8'd5, 2'd0, 24'h777777, 64'h0,
                    0, 0, 24'h0, 16'h0, 1'b0, 8, 1'b0, 1'b1};
        vecs[4] = '{"bad_layer", 1'b0, 8'd5, 8'd5, 2'd3, 24'h777777, 64'h1,
                    0, 0, 24'h0, 16'h0, 1'b1, 0, 1'b0, 1'b0};
        vecs[5] = '{"stall7", 1'b0, 8'd3, 8'd2, 2'd1, 24'h00FF00, 64'h0A50,
                    7, 1, 24'h010203, 16'h0FF0, 1'b0, 25, 1'b1, 1'b0};
        vecs[6] = '{"y_wrap", 1'b0, 8'h22, 8'd255, 2'd1, 24'hABCDEF, 64'h0003_0000,
                    1, 1, 24'h010022, 16'h0003, 1'b0, 13, 1'b0, 1'b0};
        vecs[7] = '{"px15_layer2", 1'b1, 8'd0, 8'd1, 2'd2, 24'h123456, 64'h8000,
                    2, 1, 24'h020100, 16'h8000, 1'b0, 15, 1'b0, 1'b1};

        n_rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; x0 = '0; y0 = '0;
        layer_sel = '0; color = '0; row_mask = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ctrl", {busy, done, err, mem_req, mem_we}, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // Abort during the third row's WRITE
        v = '{"abort", 1'b0, 8'd0, 8'd0, 2'd0, 24'hFFFFFF, 64'h0000_0001_0001_0001,
              3, 0, 24'h0, 16'h0, 1'b0, 0, 1'b0, 1'b0};
        rd_cnt = 0; wr_cnt = 0; ack_delay = 3;
        mode = v.mode; x0 = v.x0; y0 = v.y0; layer_sel = v.layer; color = v.color;
        row_mask = v.mask; start = 1'b1;
        tick();
        start = 1'b0;
        wait_cyc = 0;
        while (!(rd_cnt == 3 && mem_req && mem_we) && wait_cyc < 200) begin
            tick();
            wait_cyc++;
        end
        chk("abort_reached_write3", (rd_cnt == 3 && mem_req && mem_we), 1);
        n0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {busy, mem_req, mem_we}, 0);
        repeat (10) tick();
        chk("abort_no_done", done_cnt, n0);
        chk("abort_row3_unwritten", wr_cnt, 2);

        // Asynchronous reset in the middle of a READ
        ack_delay = 20;
        mode = 1'b0; x0 = 8'd10; y0 = 8'd20; layer_sel = 2'd0; color = 24'h00FF00;
        row_mask = 64'h1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_cyc = 0;
        while (!(mem_req && !mem_we) && wait_cyc < 30) begin
            tick();
            wait_cyc++;
        end
        tick();
        chk("rst_reached_read", {mem_req, mem_we}, 2'b10);
        #1;
        n_rst = 1'b0;
        #1;
        chk("rst_async_ctrl", {busy, done, err, mem_req, mem_we}, 0);
        chk("rst_async_addr", mem_addr, 0);
        chk("rst_async_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        run_job(vecs[0]);

        chk("addr_wdata_stable", stab_err, 0);
        chk("req_gap_after_ack", gap_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
